// File: rtl/bin_sched_ctrl.sv
// Bin scheduler for the bin-based SAT flow: walks bins, drives loader, SAT core and backtracker.
// Optional watchdog on the wait states is enabled with `define SCHED_WATCHDOG_EN.
module bin_sched_ctrl #(
   parameter int unsigned WIDTH_BIN_I = 10,
   parameter int unsigned WIDTH_LVL   = 10,
   parameter int unsigned WDOG_CYCLES = 4096
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start_i,
   input  logic                   abort_i,
   input  logic [WIDTH_BIN_I-1:0] num_bins_i,
   output logic                   start_load_update_o,
   output logic                   first_load_update_o,
   output logic [WIDTH_BIN_I-1:0] request_bin_num_o,
   input  logic                   load_update_done_i,
   output logic                   start_core_o,
   input  logic                   core_done_i,
   input  logic [1:0]             core_result_i,
   input  logic [WIDTH_LVL-1:0]   core_bkt_lvl_i,
   input  logic [WIDTH_BIN_I-1:0] core_bkt_bin_i,
   output logic                   start_backtrack_o,
   output logic [WIDTH_LVL-1:0]   bkt_lvl_o,
   input  logic                   backtrack_done_i,
   output logic                   busy_o,
   output logic                   done_o,
   output logic                   global_sat_o,
   output logic                   global_unsat_o,
   output logic                   timeout_o,
   output logic [15:0]            load_cnt_o
);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_WAIT_LOAD, S_RUN, S_WAIT_CORE, S_BKT, S_WAIT_BKT, S_FINISH
   } state_t;

   state_t                 r_state;
   logic [WIDTH_BIN_I-1:0] r_num_bins;
   logic [WIDTH_BIN_I-1:0] r_bin_cur;
   logic                   r_first;
   logic [WIDTH_LVL-1:0]   r_bkt_lvl;
   logic [15:0]            r_load_cnt;
   logic                   r_sat;
   logic                   r_unsat;
   logic [WIDTH_BIN_I-1:0] w_bin_next;
   logic [WIDTH_BIN_I-1:0] w_bkt_bin;
   logic                   w_wdog_hit;

   assign w_bin_next = r_bin_cur + WIDTH_BIN_I'(1);
   assign w_bkt_bin  = (core_bkt_bin_i < r_bin_cur) ? core_bkt_bin_i : r_bin_cur;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state    <= S_IDLE;
         r_num_bins <= '0;
         r_bin_cur  <= '0;
         r_first    <= 1'b1;
         r_bkt_lvl  <= '0;
         r_load_cnt <= '0;
         r_sat      <= 1'b0;
         r_unsat    <= 1'b0;
      end else if (abort_i && r_state != S_IDLE) begin
         r_state <= S_IDLE;
         r_sat   <= 1'b0;
         r_unsat <= 1'b0;
      end else begin
         unique case (r_state)
            S_IDLE: if (start_i) begin
               r_num_bins <= num_bins_i;
               r_load_cnt <= '0;
               r_sat      <= 1'b0;
               r_unsat    <= 1'b0;
               r_first    <= 1'b1;
               r_bin_cur  <= '0;
               if (num_bins_i == '0) begin
                  r_state <= S_FINISH;
                  r_sat   <= 1'b1;
               end else begin
                  r_state <= S_LOAD;
               end
            end
            S_LOAD: begin
               if (r_load_cnt != '1) r_load_cnt <= r_load_cnt + 16'd1;
               r_state <= S_WAIT_LOAD;
            end
            S_WAIT_LOAD: if (load_update_done_i) begin
               r_first <= 1'b0;
               r_state <= S_RUN;
            end else if (w_wdog_hit) begin
               r_state <= S_FINISH;
            end
            S_RUN: r_state <= S_WAIT_CORE;
            // result 00 with core_done_i is a no-op; real verdicts beat the watchdog
            S_WAIT_CORE: if (core_done_i && core_result_i != 2'b00) begin
               case (core_result_i)
                  2'b01: begin
                     r_bin_cur <= w_bin_next;
                     if (w_bin_next == r_num_bins) begin
                        r_state <= S_FINISH;
                        r_sat   <= 1'b1;
                     end else begin
                        r_state <= S_LOAD;
                     end
                  end
                  2'b10: if (core_bkt_lvl_i == '0) begin
                     r_state <= S_FINISH;
                     r_unsat <= 1'b1;
                  end else begin
                     r_bkt_lvl <= core_bkt_lvl_i;
                     r_bin_cur <= w_bkt_bin;
                     r_state   <= S_BKT;
                  end
                  default: begin
                     r_state <= S_FINISH;
                     r_unsat <= 1'b1;
                  end
               endcase
            end else if (w_wdog_hit) begin
               r_state <= S_FINISH;
            end
            S_BKT: r_state <= S_WAIT_BKT;
            S_WAIT_BKT: if (backtrack_done_i) begin
               r_state <= S_LOAD;
            end else if (w_wdog_hit) begin
               r_state <= S_FINISH;
            end
            S_FINISH: r_state <= S_IDLE;
            default:  r_state <= S_IDLE;
         endcase
      end
   end

`ifdef SCHED_WATCHDOG_EN
   localparam int unsigned WDOG_W = $clog2(WDOG_CYCLES + 1);
   logic [WDOG_W-1:0] r_wdog;
   logic              r_timeout;
   logic              w_in_wait;
   logic              w_wait_evt;

   assign w_in_wait  = (r_state == S_WAIT_LOAD) || (r_state == S_WAIT_CORE) ||
                       (r_state == S_WAIT_BKT);
   assign w_wait_evt = (r_state == S_WAIT_LOAD && load_update_done_i) ||
                       (r_state == S_WAIT_CORE && core_done_i && core_result_i != 2'b00) ||
                       (r_state == S_WAIT_BKT && backtrack_done_i);
   assign w_wdog_hit = w_in_wait && (r_wdog == WDOG_W'(WDOG_CYCLES - 1));

   // wait states are only entered from non-wait states, so clearing outside them covers every state change
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_wdog    <= '0;
         r_timeout <= 1'b0;
      end else if (abort_i && r_state != S_IDLE) begin
         r_wdog    <= '0;
         r_timeout <= 1'b0;
      end else begin
         r_wdog <= w_in_wait ? r_wdog + WDOG_W'(1) : '0;
         if (r_state == S_IDLE && start_i) r_timeout <= 1'b0;
         else if (w_wdog_hit && !w_wait_evt) r_timeout <= 1'b1;
      end
   end

   assign timeout_o = r_timeout;
`else
   assign w_wdog_hit = 1'b0;
   assign timeout_o  = 1'b0;
`endif

   assign start_load_update_o = (r_state == S_LOAD);
   assign first_load_update_o = (r_state == S_LOAD) && r_first;
   assign request_bin_num_o   = r_bin_cur;
   assign start_core_o        = (r_state == S_RUN);
   assign start_backtrack_o   = (r_state == S_BKT);
   assign bkt_lvl_o           = r_bkt_lvl;
   assign busy_o              = (r_state != S_IDLE);
   assign done_o              = (r_state == S_FINISH);
   assign global_sat_o        = r_sat;
   assign global_unsat_o      = r_unsat;
   assign load_cnt_o          = r_load_cnt;

endmodule

// File: tb/tb_bin_sched_ctrl.sv
// Self-checking bench for bin_sched_ctrl: directed scenarios plus randomized solves
// checked against an algorithm-level model of the bin walk.
module tb_bin_sched_ctrl;
  localparam int unsigned WB = 10;
  localparam int unsigned WL = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start_i = 1'b0, abort_i = 1'b0;
  logic [WB-1:0] num_bins_i = '0;
  logic          start_load_update_o, first_load_update_o;
  logic [WB-1:0] request_bin_num_o;
  logic          load_update_done_i = 1'b0;
  logic          start_core_o;
  logic          core_done_i = 1'b0;
  logic [1:0]    core_result_i = '0;
  logic [WL-1:0] core_bkt_lvl_i = '0;
  logic [WB-1:0] core_bkt_bin_i = '0;
  logic          start_backtrack_o;
  logic [WL-1:0] bkt_lvl_o;
  logic          backtrack_done_i = 1'b0;
  logic          busy_o, done_o, global_sat_o, global_unsat_o, timeout_o;
  logic [15:0]   load_cnt_o;

  int errors = 0;
  int checks = 0;

  int s_res[$], s_lvl[$], s_bin[$];
  int e_bins[$], e_lvls[$];
  bit e_sat;

  always #5 clk = ~clk;

  bin_sched_ctrl #(.WIDTH_BIN_I(WB), .WIDTH_LVL(WL), .WDOG_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .abort_i(abort_i), .num_bins_i(num_bins_i),
    .start_load_update_o(start_load_update_o), .first_load_update_o(first_load_update_o),
    .request_bin_num_o(request_bin_num_o), .load_update_done_i(load_update_done_i),
    .start_core_o(start_core_o), .core_done_i(core_done_i), .core_result_i(core_result_i),
    .core_bkt_lvl_i(core_bkt_lvl_i), .core_bkt_bin_i(core_bkt_bin_i),
    .start_backtrack_o(start_backtrack_o), .bkt_lvl_o(bkt_lvl_o),
    .backtrack_done_i(backtrack_done_i), .busy_o(busy_o), .done_o(done_o),
    .global_sat_o(global_sat_o), .global_unsat_o(global_unsat_o), .timeout_o(timeout_o),
    .load_cnt_o(load_cnt_o)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_inputs();
    start_i = 1'b0; abort_i = 1'b0; load_update_done_i = 1'b0;
    core_done_i = 1'b0; core_result_i = '0; backtrack_done_i = 1'b0;
  endtask

  // Algorithm-level reference: the sequence of bins loaded, backtrack levels and verdict.
  task automatic model(input int n);
    int bin = 0;
    int k = 0;
    e_bins.delete(); e_lvls.delete(); e_sat = 1'b0;
    if (n == 0) begin e_sat = 1'b1; return; end
    while (k < s_res.size()) begin
      e_bins.push_back(bin);
      if (s_res[k] == 1) begin
        bin++;
        if (bin == n) begin e_sat = 1'b1; return; end
      end else if (s_res[k] == 2 && s_lvl[k] != 0) begin
        e_lvls.push_back(s_lvl[k]);
        if (s_bin[k] < bin) bin = s_bin[k];
      end else begin
        return;
      end
      k++;
    end
  endtask

  task automatic script_all_sat(input int len);
    s_res.delete(); s_lvl.delete(); s_bin.delete();
    for (int unsigned i = 0; i < len; i++) begin
      s_res.push_back(1); s_lvl.push_back(0); s_bin.push_back(0);
    end
  endtask

  task automatic run_solve(input int n, input bit noise);
    int obs_bins[$], obs_first[$], obs_cnt[$], obs_lvls[$];
    int ld_w = 0, cr_w = 0, bk_w = 0, k = 0;
    int last_evt = -1, ld_cyc = -100, done_cyc = -1;
    bit got_done = 1'b0;
    bit noised = 1'b0;
    model(n);
    start_i = 1'b1; num_bins_i = WB'(n);
    cyc();
    start_i = 1'b0; num_bins_i = WB'($urandom_range(0, 1023));
    checks++;
    if (start_load_update_o !== (n > 0)) begin
      errors++;
      $display("FAIL start_latency n=%0d: load pulse=%0b expected=%0b", n, start_load_update_o, n > 0);
    end
    for (int cc = 0; cc < 3000 && !got_done; cc++) begin
      clr_inputs();
      if (done_o === 1'b1) begin
        got_done = 1'b1; done_cyc = cc;
      end else begin
        if (start_load_update_o) begin
          obs_bins.push_back(int'(request_bin_num_o));
          obs_first.push_back(int'(first_load_update_o));
          obs_cnt.push_back(int'(load_cnt_o));
          ld_w = $urandom_range(1, 4);
          if (noise && $urandom_range(0, 2) == 0) begin
            core_done_i = 1'b1; core_result_i = 2'b01; backtrack_done_i = 1'b1;
          end
        end else if (ld_w > 0) begin
          ld_w--;
          if (ld_w == 0) begin load_update_done_i = 1'b1; ld_cyc = cc; end
        end
        if (start_core_o) begin
          checks++;
          if (cc != ld_cyc + 1) begin
            errors++;
            $display("FAIL core_latency: start_core at cycle %0d expected %0d", cc, ld_cyc + 1);
          end
          cr_w = $urandom_range(1, 4); noised = 1'b0;
        end else if (cr_w > 0) begin
          cr_w--;
          if (cr_w == 0) begin
            core_done_i = 1'b1;
            if (noise && !noised && $urandom_range(0, 3) == 0) begin
              core_result_i = 2'b00; cr_w = 1; noised = 1'b1;
            end else begin
              core_result_i  = (k < s_res.size()) ? 2'(s_res[k]) : 2'b01;
              core_bkt_lvl_i = (k < s_res.size()) ? WL'(s_lvl[k]) : '0;
              core_bkt_bin_i = (k < s_res.size()) ? WB'(s_bin[k]) : '0;
              k++; last_evt = cc;
            end
          end
        end
        if (start_backtrack_o) begin
          obs_lvls.push_back(int'(bkt_lvl_o));
          bk_w = $urandom_range(1, 4);
        end else if (bk_w > 0) begin
          bk_w--;
          if (bk_w == 0) backtrack_done_i = 1'b1;
        end
        if (noise && $urandom_range(0, 7) == 0) begin
          start_i = 1'b1; num_bins_i = WB'($urandom_range(0, 1023));
        end
        cyc();
      end
    end
    clr_inputs();
    checks++;
    if (!got_done) begin
      errors++;
      $display("FAIL solve_timeout n=%0d: done_o never seen, expected within 3000 cycles", n);
      return;
    end
    checks++;
    if (done_cyc != last_evt + 1) begin
      errors++;
      $display("FAIL done_latency: done at cycle %0d expected %0d", done_cyc, last_evt + 1);
    end
    checks++;
    if (global_sat_o !== e_sat || global_unsat_o !== !e_sat || timeout_o !== 1'b0) begin
      errors++;
      $display("FAIL verdict n=%0d: sat=%0b unsat=%0b to=%0b expected sat=%0b unsat=%0b to=0",
               n, global_sat_o, global_unsat_o, timeout_o, e_sat, !e_sat);
    end
    checks++;
    if (int'(load_cnt_o) != e_bins.size()) begin
      errors++;
      $display("FAIL load_cnt: got %0d expected %0d", load_cnt_o, e_bins.size());
    end
    checks++;
    if (obs_bins.size() != e_bins.size()) begin
      errors++;
      $display("FAIL load_count_seq: got %0d loads expected %0d", obs_bins.size(), e_bins.size());
    end
    for (int i = 0; i < obs_bins.size() && i < e_bins.size(); i++) begin
      checks++;
      if (obs_bins[i] != e_bins[i] || obs_first[i] != (i == 0) || obs_cnt[i] != i) begin
        errors++;
        $display("FAIL load[%0d]: bin=%0d first=%0d cnt=%0d expected bin=%0d first=%0d cnt=%0d",
                 i, obs_bins[i], obs_first[i], obs_cnt[i], e_bins[i], i == 0, i);
      end
    end
    checks++;
    if (obs_lvls.size() != e_lvls.size()) begin
      errors++;
      $display("FAIL bkt_count: got %0d expected %0d", obs_lvls.size(), e_lvls.size());
    end
    for (int i = 0; i < obs_lvls.size() && i < e_lvls.size(); i++) begin
      checks++;
      if (obs_lvls[i] != e_lvls[i]) begin
        errors++;
        $display("FAIL bkt_lvl[%0d]: got %0d expected %0d", i, obs_lvls[i], e_lvls[i]);
      end
    end
    cyc();
    checks++;
    if (busy_o !== 1'b0 || done_o !== 1'b0 || global_sat_o !== e_sat) begin
      errors++;
      $display("FAIL post_idle: busy=%0b done=%0b sat=%0b expected busy=0 done=0 sat=%0b",
               busy_o, done_o, global_sat_o, e_sat);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; clr_inputs();
    cyc(); cyc();
    checks++;
    if ({start_load_update_o, first_load_update_o, start_core_o, start_backtrack_o,
         busy_o, done_o, global_sat_o, global_unsat_o, timeout_o} !== 9'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 000000000",
               {start_load_update_o, first_load_update_o, start_core_o, start_backtrack_o,
                busy_o, done_o, global_sat_o, global_unsat_o, timeout_o});
    end
    checks++;
    if (request_bin_num_o !== '0 || bkt_lvl_o !== '0 || load_cnt_o !== 16'd0) begin
      errors++;
      $display("FAIL reset_data: req=%0d lvl=%0d cnt=%0d expected 0 0 0",
               request_bin_num_o, bkt_lvl_o, load_cnt_o);
    end
    rst = 1'b1;
    cyc();
  endtask

  task automatic test_mid_reset();
    start_i = 1'b1; num_bins_i = WB'(5);
    cyc(); start_i = 1'b0;
    cyc(); load_update_done_i = 1'b1;
    cyc(); load_update_done_i = 1'b0;
    cyc();
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    checks++;
    if (busy_o !== 1'b0 || load_cnt_o !== 16'd0 || start_core_o !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: busy=%0b cnt=%0d core=%0b expected 0 0 0",
               busy_o, load_cnt_o, start_core_o);
    end
    script_all_sat(8);
    run_solve(2, 1'b0);
  endtask

  task automatic test_all_sat();
    script_all_sat(8);
    run_solve(3, 1'b0);
  endtask

  task automatic test_backtrack();
    s_res = '{1, 1, 2, 1, 1, 1, 1, 1};
    s_lvl = '{0, 0, 5, 0, 0, 0, 0, 0};
    s_bin = '{0, 0, 1, 0, 0, 0, 0, 0};
    run_solve(4, 1'b0);
  endtask

  task automatic test_unsat();
    s_res = '{1, 2, 1}; s_lvl = '{0, 0, 0}; s_bin = '{0, 0, 0};
    run_solve(3, 1'b0);
    s_res = '{3, 1}; s_lvl = '{0, 0}; s_bin = '{0, 0};
    run_solve(2, 1'b0);
  endtask

  task automatic test_zero_bins();
    script_all_sat(2);
    run_solve(0, 1'b0);
  endtask

  task automatic test_abort();
    bit seen_done = 1'b0;
    start_i = 1'b1; num_bins_i = WB'(3);
    cyc(); start_i = 1'b0;
    cyc(); load_update_done_i = 1'b1;
    cyc(); load_update_done_i = 1'b0;
    cyc();
    abort_i = 1'b1; core_done_i = 1'b1; core_result_i = 2'b01;
    cyc(); clr_inputs();
    checks++;
    if (busy_o !== 1'b0 || done_o !== 1'b0 || start_load_update_o !== 1'b0 ||
        global_sat_o !== 1'b0 || global_unsat_o !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle: busy=%0b done=%0b load=%0b sat=%0b unsat=%0b expected all 0",
               busy_o, done_o, start_load_update_o, global_sat_o, global_unsat_o);
    end
    for (int unsigned i = 0; i < 4; i++) begin
      if (done_o === 1'b1 || busy_o === 1'b1) seen_done = 1'b1;
      cyc();
    end
    checks++;
    if (seen_done) begin
      errors++;
      $display("FAIL abort_quiet: done/busy activity=1 expected 0");
    end
    script_all_sat(8);
    run_solve(3, 1'b0);
  endtask

  task automatic test_random();
    for (int unsigned it = 0; it < 25; it++) begin
      int n;
      n = $urandom_range(1, 6);
      s_res.delete(); s_lvl.delete(); s_bin.delete();
      for (int unsigned i = 0; i < 40; i++) begin
        int r;
        r = $urandom_range(0, 19);
        if (i >= 12 || r < 13) begin
          s_res.push_back(1); s_lvl.push_back(0); s_bin.push_back(0);
        end else if (r < 19) begin
          s_res.push_back(2); s_lvl.push_back($urandom_range(0, 7));
          s_bin.push_back($urandom_range(0, n - 1));
        end else begin
          s_res.push_back(3); s_lvl.push_back(0); s_bin.push_back(0);
        end
      end
      run_solve(n, 1'b1);
    end
  endtask

`ifdef SCHED_WATCHDOG_EN
  task automatic test_watchdog();
    int done_cyc = -1;
    start_i = 1'b1; num_bins_i = WB'(2);
    cyc(); start_i = 1'b0;
    for (int cc = 0; cc < 100 && done_cyc < 0; cc++) begin
      if (done_o === 1'b1) done_cyc = cc;
      else cyc();
    end
    checks++;
    if (done_cyc != 17) begin
      errors++;
      $display("FAIL wdog_latency: done at cycle %0d expected 17", done_cyc);
    end
    checks++;
    if (timeout_o !== 1'b1 || global_sat_o !== 1'b0 || global_unsat_o !== 1'b0) begin
      errors++;
      $display("FAIL wdog_flags: to=%0b sat=%0b unsat=%0b expected 1 0 0",
               timeout_o, global_sat_o, global_unsat_o);
    end
    cyc(); cyc();
  endtask
`endif

  initial begin
    test_reset();
    test_all_sat();
    test_backtrack();
    test_unsat();
    test_zero_bins();
    test_abort();
    test_mid_reset();
    test_random();
`ifdef SCHED_WATCHDOG_EN
    test_watchdog();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
